port_out_arbiter: RTL and testbench

//  Round-robin arbiter that shares the memory-mapped output-port write bus between N_REQ masters,
//  e.g. CPU, loader, debug and timer. It drives the address/data_in/write inputs of the 16-port

---
 rtl/port_out_arbiter.sv | 150 +++++++++++++++
 tb/tb_port_out_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_out_arbiter.sv
// Round-robin arbiter sharing the output-port write bus between N_REQ masters.
// One access per grant: an in-window address produces a single write strobe,
// an out-of-window address is answered with ack+err and no write.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | bus quiet, sampling req on every edge for the next winner
// WRITE  | write strobe high for the latched access, ack to the winner
// REJECT | latched address outside the port window, ack+err, no write
module port_out_arbiter #(
    parameter int          N_REQ      = 4,
    parameter logic [7:0]  PORT_BASE  = 8'hE0,
    parameter int          PORT_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [7:0]           address,
    output logic [7:0]           data_out,
    output logic                 write,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // 9-bit window bounds so PORT_BASE+PORT_COUNT = 256 does not wrap to 0
    localparam logic [8:0] WIN_LO = 9'(PORT_BASE);
    localparam logic [8:0] WIN_HI = 9'(int'(PORT_BASE) + PORT_COUNT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        REJECT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    win, win_nxt;
    logic [7:0]          addr_nxt;
    logic [7:0]          data_nxt;

    logic [2*N_REQ-1:0]  req_dbl;
    logic [N_REQ-1:0]    req_rot;
    logic [IDX_W-1:0]    pick;
    logic [7:0]          pick_addr;
    logic [7:0]          pick_data;
    logic                pick_in_window;

    // Rotate requests so bit 0 corresponds to the requester at ptr
    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> ptr);

    // First requester at or after ptr, folded back into 0..N_REQ-1
    always_comb begin
        logic        found;
        logic [IDX_W:0] sum;
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDX_W+1)'(j);
                if (sum >= N_WIDE) begin
                    sum = sum - N_WIDE;
                end
                pick = sum[IDX_W-1:0];
            end
        end
    end

    // Select the winner's address and data from the packed request buses
    always_comb begin
        pick_addr = 8'h00;
        pick_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_addr = req_addr[8*i +: 8];
                pick_data = req_data[8*i +: 8];
            end
        end
    end

    // Window check on the selected address
    always_comb begin
        pick_in_window = ({1'b0, pick_addr} >= WIN_LO) && ({1'b0, pick_addr} < WIN_HI);
    end

    // Next-state: grant only from IDLE, every grant lasts one cycle
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        addr_nxt  = address;
        data_nxt  = data_out;
        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt   = pick;
                    addr_nxt  = pick_addr;
                    data_nxt  = pick_data;
                    state_nxt = pick_in_window ? WRITE : REJECT;
                end
            end
            WRITE, REJECT: begin
                ptr_nxt   = (win == LAST_IDX) ? '0 : win + 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, winner and latched bus registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            address  <= 8'h00;
            data_out <= 8'h00;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            win      <= win_nxt;
            address  <= addr_nxt;
            data_out <= data_nxt;
        end
    end

    // Strobes decode from registered state only, so reset drops them at once
    always_comb begin
        write = (state == WRITE);
        err   = (state == REJECT);
        busy  = (state != IDLE);
        ack   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = busy && (win == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_port_out_arbiter.sv
// Directed bench for port_out_arbiter: a table of single-requester accesses
// plus hand-written sequences for rotation, fairness and mid-write reset.
module tb_port_out_arbiter;

    localparam int N = 4;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_addr;
    logic [8*N-1:0]   req_data;
    logic [7:0]       address;
    logic [7:0]       data_out;
    logic             write;
    logic [N-1:0]     ack;
    logic             err;
    logic             busy;

    int tests;
    int fails;

    port_out_arbiter #(
        .N_REQ(N),
        .PORT_BASE(8'hE0),
        .PORT_COUNT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
        .address(address),
        .data_out(data_out),
        .write(write),
        .ack(ack),
        .err(err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         who;
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_write;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] d);
        req_addr[8*i +: 8] = a;
        req_data[8*i +: 8] = d;
        req[i] = 1'b1;
    endtask

    // Tick until ack shows up or the budget runs out
    task automatic wait_ack(input string name, output logic [N-1:0] got);
        got = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack != '0) begin
                got = ack;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL %s: no ack within 8 cycles", name);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [N-1:0] got;
        logic [N-1:0] exp_ack;
        logic [N-1:0] prev_ack;

        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;

        vecs[0] = '{0, 8'hE3, 8'h5A, 1'b1, 1'b0};
        vecs[1] = '{1, 8'h10, 8'h77, 1'b0, 1'b1};
        vecs[2] = '{1, 8'hF0, 8'h11, 1'b0, 1'b1};
        vecs[3] = '{1, 8'hEF, 8'h22, 1'b1, 1'b0};
        vecs[4] = '{2, 8'hE0, 8'h33, 1'b1, 1'b0};
        vecs[5] = '{3, 8'hDF, 8'h44, 1'b0, 1'b1};
        vecs[6] = '{3, 8'hFF, 8'h55, 1'b0, 1'b1};
        vecs[7] = '{0, 8'h00, 8'h66, 1'b0, 1'b1};

        // Reset held with random requests: everything stays at reset values
        for (int r = 0; r < 4; r++) begin
            req      = N'($urandom);
            req_addr = $urandom;
            req_data = $urandom;
            tick();
            chk("rst_addr",  32'(address),  32'h00);
            chk("rst_data",  32'(data_out), 32'h00);
            chk("rst_write", 32'(write),    32'h0);
            chk("rst_ack",   32'(ack),      32'h0);
            chk("rst_err",   32'(err),      32'h0);
            chk("rst_busy",  32'(busy),     32'h0);
        end
        req   = '0;
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_addr",  32'(address), 32'h00);
        chk("post_rst_write", 32'(write),   32'h0);
        chk("post_rst_busy",  32'(busy),    32'h0);

        // Table: one requester at a time, in-window writes and rejects
        for (int v = 0; v < 8; v++) begin
            exp_ack = N'(1) << vecs[v].who;
            set_req(vecs[v].who, vecs[v].addr, vecs[v].data);
            tick();
            chk($sformatf("v%0d_write", v), 32'(write),    32'(vecs[v].exp_write));
            chk($sformatf("v%0d_err", v),   32'(err),      32'(vecs[v].exp_err));
            chk($sformatf("v%0d_ack", v),   32'(ack),      32'(exp_ack));
            chk($sformatf("v%0d_addr", v),  32'(address),  32'(vecs[v].addr));
            chk($sformatf("v%0d_data", v),  32'(data_out), 32'(vecs[v].data));
            chk($sformatf("v%0d_busy", v),  32'(busy),     32'h1);
            tick();
            req = '0;
            chk($sformatf("v%0d_idle_write", v), 32'(write), 32'h0);
            chk($sformatf("v%0d_idle_ack", v),   32'(ack),   32'h0);
            chk($sformatf("v%0d_idle_busy", v),  32'(busy),  32'h0);
            tick();
            chk($sformatf("v%0d_no_rewrite", v), 32'(write), 32'h0);
            chk($sformatf("v%0d_hold_addr", v),  32'(address), 32'(vecs[v].addr));
        end

        // All four request after reset: rotating service 0,1,2,3 on alternate cycles
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 8'hE0 + 8'(i), 8'hA0 + 8'(i));
        end
        for (int g = 0; g < N; g++) begin
            tick();
            chk($sformatf("rr%0d_ack", g),   32'(ack),      32'(N'(1) << g));
            chk($sformatf("rr%0d_write", g), 32'(write),    32'h1);
            chk($sformatf("rr%0d_addr", g),  32'(address),  32'(8'hE0 + 8'(g)));
            chk($sformatf("rr%0d_data", g),  32'(data_out), 32'(8'hA0 + 8'(g)));
            tick();
            chk($sformatf("rr%0d_gap", g),   32'(write),    32'h0);
            req[g] = 1'b0;
        end
        // Pointer wrapped to 0: with req 0 and 1 pending, 0 wins
        set_req(0, 8'hE4, 8'h01);
        set_req(1, 8'hE5, 8'h02);
        tick();
        chk("ptr_wrap_ack", 32'(ack), 32'b0001);
        tick();
        req = '0;
        tick();

        // Fairness: req0 and req2 held; ptr is 1 so 2 goes first, then strict alternation
        set_req(0, 8'hE1, 8'h10);
        set_req(2, 8'hE2, 8'h20);
        exp_ack  = 4'b0100;
        prev_ack = '0;
        for (int g = 0; g < 20; g++) begin
            wait_ack($sformatf("fair%0d_wait", g), got);
            chk($sformatf("fair%0d_ack", g), 32'(got), 32'(exp_ack));
            if (g > 0) begin
                tests++;
                if (got == prev_ack) begin
                    fails++;
                    $display("FAIL fair%0d_repeat: got %0h twice in a row", g, got);
                end
            end
            prev_ack = got;
            exp_ack  = (exp_ack == 4'b0100) ? 4'b0001 : 4'b0100;
            tick();
        end
        req = '0;
        tick();
        chk("fair_end_idle", 32'(busy), 32'h0);

        // Reset during WRITE: strobes drop in the same cycle, req3 served after release
        set_req(3, 8'hE5, 8'h66);
        tick();
        chk("mid_rst_pre_write", 32'(write), 32'h1);
        chk("mid_rst_pre_ack",   32'(ack),   32'b1000);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_write", 32'(write),   32'h0);
        chk("mid_rst_ack",   32'(ack),     32'h0);
        chk("mid_rst_addr",  32'(address), 32'h00);
        #2;
        reset = 1'b1;
        wait_ack("mid_rst_serve_wait", got);
        chk("mid_rst_serve_ack",   32'(got),      32'b1000);
        chk("mid_rst_serve_write", 32'(write),    32'h1);
        chk("mid_rst_serve_data",  32'(data_out), 32'h66);
        tick();
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global timeout so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
